// File: rtl/cdc_pkg.sv
// cdc_pkg: shared state encoding and synchronizer depth for the req/ack crossing
package cdc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RELEASE = 2'd2, RSVD = 2'd3} state_t;
    localparam int SYNC_DEPTH = 3;
endpackage

// File: rtl/sync3d_rst0.sv
// sync3d_rst0: 3-flop single-bit synchronizer, asynchronously reset to 0
module sync3d_rst0
    import cdc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  d,
    output logic                  q,
    output logic [SYNC_DEPTH-1:0] chain
);
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) chain <= '0;
        else chain <= {chain[SYNC_DEPTH-2:0], d};
    end
    assign q = chain[SYNC_DEPTH-1];
endmodule

// File: rtl/cdc_req_ack_tx.sv
// cdc_req_ack_tx: launch-side 4-phase req/ack transmitter with watchdog and transfer counter
module cdc_req_ack_tx
    import cdc_pkg::*;
#(
    parameter int DW   = 32,
    parameter int TO_W = 8
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    output logic          xfer_req,
    output logic [DW-1:0] xfer_data,
    input  logic          xfer_ack,
    output logic          busy,
    output logic [15:0]   xfer_cnt,
    output logic          to_err
);
    state_t                state, state_n;
    logic [TO_W-1:0]       wd, wd_n;
    logic                  ack_s, alive, accept;
    logic [SYNC_DEPTH-1:0] ack_chain;

    sync3d_rst0 u_ack_sync (
        .clk    (clk),
        .reset_ (reset_),
        .d      (xfer_ack),
        .q      (ack_s),
        .chain  (ack_chain)
    );

    // A stale ack anywhere in the chain blocks new words until it has fully drained.
    assign busy      = state != IDLE;
    assign src_ready = alive && state == IDLE && ack_chain == '0;
    assign accept    = src_valid && src_ready;

    always_comb begin
        state_n = state == IDLE    ? (accept ? REQ : IDLE) :
                  state == REQ     ? (ack_s ? RELEASE : REQ) :
                  state == RELEASE ? (ack_s ? RELEASE : IDLE) : IDLE;
        wd_n    = state_n != state      ? '0 :
                  busy && wd != '1      ? wd + TO_W'(1) : wd;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= IDLE;
            wd        <= '0;
            alive     <= 1'b0;
            xfer_req  <= 1'b0;
            xfer_data <= '0;
            xfer_cnt  <= '0;
            to_err    <= 1'b0;
        end else begin
            state    <= state_n;
            wd       <= wd_n;
            alive    <= 1'b1;
            xfer_req <= state_n == REQ;
            to_err   <= to_err | (wd_n == '1);
            if (accept) xfer_data <= src_data;
            if (state == RELEASE && state_n == IDLE) xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_cdc_req_ack_tx.sv
// tb_cdc_req_ack_tx: directed self-checking bench for cdc_req_ack_tx
module tb_cdc_req_ack_tx;
    logic        clk = 1'b0;
    logic        reset_;
    logic        src_valid;
    logic [31:0] src_data;
    logic        src_ready;
    logic        xfer_req;
    logic [31:0] xfer_data;
    logic        xfer_ack;
    logic        busy;
    logic [15:0] xfer_cnt;
    logic        to_err;
    logic        resp_en, man_ack;
    logic [1:0]  rpipe = 2'b00;
    int          n_cmp = 0, n_err = 0;

    cdc_req_ack_tx #(.DW(32), .TO_W(4)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .xfer_req  (xfer_req),
        .xfer_data (xfer_data),
        .xfer_ack  (xfer_ack),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt),
        .to_err    (to_err)
    );

    always #5 clk = ~clk;

    // Destination model: ack follows req two cycles later, both edges.
    always @(negedge clk) rpipe <= {rpipe[0], xfer_req};
    assign xfer_ack = resp_en ? rpipe[1] : man_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 60 && src_ready !== 1'b1; k++) @(negedge clk);
        chk(tag, 32'(src_ready), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 100 && busy !== 1'b0; k++) @(negedge clk);
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_ = 1'b0; src_valid = 1'b0; src_data = '0; resp_en = 1'b0; man_ack = 1'b0;
        cyc(2);
        chk("rst_ready", 32'(src_ready), 32'd0);
        chk("rst_req",   32'(xfer_req),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_cnt",   32'(xfer_cnt),  32'd0);
        chk("rst_data",  xfer_data,      32'd0);
        chk("rst_toerr", 32'(to_err),    32'd0);
        reset_ = 1'b1;
        cyc(1);
        chk("first_ready", 32'(src_ready), 32'd1);

        // Basic transfer with exact A/B edge latency
        src_valid = 1'b1; src_data = 32'hA5A5_0001;
        cyc(1);
        src_valid = 1'b0; src_data = 32'h0;
        chk("e0_req",   32'(xfer_req),  32'd1);
        chk("e0_data",  xfer_data,      32'hA5A5_0001);
        chk("e0_ready", 32'(src_ready), 32'd0);
        chk("e0_busy",  32'(busy),      32'd1);
        cyc(2);
        man_ack = 1'b1;
        cyc(3);
        chk("a3_req_held", 32'(xfer_req), 32'd1);
        cyc(1);
        chk("a4_req_low", 32'(xfer_req), 32'd0);
        chk("a4_data",    xfer_data,     32'hA5A5_0001);
        cyc(2);
        man_ack = 1'b0;
        cyc(3);
        chk("b3_busy",  32'(busy),     32'd1);
        chk("b3_cnt",   32'(xfer_cnt), 32'd0);
        cyc(1);
        chk("b4_busy",  32'(busy),      32'd0);
        chk("b4_cnt",   32'(xfer_cnt),  32'd1);
        chk("b4_ready", 32'(src_ready), 32'd1);
        chk("b4_data",  xfer_data,      32'hA5A5_0001);

        // Back-to-back: valid held, ten distinct words
        resp_en = 1'b1; src_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            src_data = 32'h0B0B_0000 + 32'(i * 17);
            wait_ready("b2b_ready");
            cyc(1);
            chk("b2b_data",  xfer_data,      32'h0B0B_0000 + 32'(i * 17));
            chk("b2b_req",   32'(xfer_req),  32'd1);
            chk("b2b_ready", 32'(src_ready), 32'd0);
        end
        src_valid = 1'b0;
        wait_idle("b2b_idle");
        chk("b2b_cnt", 32'(xfer_cnt), 32'd11);

        // Watchdog: no ack, TO_W=4 fires 15 cycles into REQ
        resp_en = 1'b0; man_ack = 1'b0;
        src_valid = 1'b1; src_data = 32'h1234_5678;
        cyc(1);
        src_valid = 1'b0;
        cyc(14);
        chk("wd_14", 32'(to_err), 32'd0);
        cyc(1);
        chk("wd_15",     32'(to_err),   32'd1);
        chk("wd_req",    32'(xfer_req), 32'd1);
        cyc(5);
        chk("wd_req_held", 32'(xfer_req), 32'd1);
        man_ack = 1'b1;
        cyc(4);
        chk("wd_late_ack", 32'(xfer_req), 32'd0);
        man_ack = 1'b0;
        cyc(4);
        chk("wd_done_busy", 32'(busy),     32'd0);
        chk("wd_done_cnt",  32'(xfer_cnt), 32'd12);
        chk("wd_sticky",    32'(to_err),   32'd1);

        // Asynchronous reset in the middle of REQ
        src_valid = 1'b1; src_data = 32'hDEAD_BEEF;
        cyc(1);
        src_valid = 1'b0;
        #2 reset_ = 1'b0;
        #1;
        chk("mid_rst_req",   32'(xfer_req), 32'd0);
        chk("mid_rst_busy",  32'(busy),     32'd0);
        chk("mid_rst_cnt",   32'(xfer_cnt), 32'd0);
        chk("mid_rst_toerr", 32'(to_err),   32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        cyc(1);
        chk("post_rst_ready", 32'(src_ready), 32'd1);
        resp_en = 1'b1; src_valid = 1'b1; src_data = 32'hCAFE_F00D;
        cyc(1);
        src_valid = 1'b0;
        wait_idle("post_rst_idle");
        chk("post_rst_cnt",  32'(xfer_cnt), 32'd1);
        chk("post_rst_data", xfer_data,     32'hCAFE_F00D);

        // Stale ack across reset release
        resp_en = 1'b0; man_ack = 1'b1; reset_ = 1'b0;
        cyc(2);
        src_valid = 1'b1; src_data = 32'h0000_0055;
        reset_ = 1'b1;
        cyc(1);
        chk("stale_ready0", 32'(src_ready), 32'd0);
        cyc(4);
        chk("stale_ready1", 32'(src_ready), 32'd0);
        chk("stale_busy",   32'(busy),      32'd0);
        man_ack = 1'b0;
        cyc(2);
        chk("stale_drain2", 32'(src_ready), 32'd0);
        cyc(1);
        chk("stale_drain3", 32'(src_ready), 32'd1);
        chk("stale_nostart", 32'(busy),     32'd0);
        cyc(1);
        chk("stale_accept", 32'(busy),     32'd1);
        chk("stale_data",   xfer_data,     32'h0000_0055);
        resp_en = 1'b1; src_valid = 1'b0;
        wait_idle("stale_idle");
        chk("stale_cnt", 32'(xfer_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
